// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences CPU data accesses (LW/LH/LHU/LB/LBU/SW/SH/SB) onto a word-addressed
//   data RAM with a combinational read port and a registered write port.
//   Sub-word stores are performed as read-modify-write. Loads are lane-extracted
//   and sign/zero extended into a registered result.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req, we, size,      request strobe and attributes, sampled only in IDLE
//   sign_ext, addr,
//   wdata
//   busy                high whenever the controller is not IDLE
//   ack                 one-cycle completion pulse
//   addr_err            qualifies ack: misaligned access, nothing written
//   rdata               load result, held until the next load completes
//   ram_rEna, ram_wEna  RAM read / write enables
//   ram_addr            RAM word address
//   ram_wdata           RAM write data
//   ram_rdata           RAM read data (combinational from ram_addr)

module mem_access_ctrl #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          sign_ext,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          busy,
  output logic          ack,
  output logic          addr_err,
  output logic [31:0]   rdata,
  output logic          ram_rEna,
  output logic          ram_wEna,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  // Request attributes captured when a request is accepted in IDLE.
  logic          we_q;
  logic [1:0]    size_q;
  logic          sext_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          err_q;
  logic [31:0]   merge_q;

  // Byte-address bits above the RAM word address are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:AW+2];

  // Alignment of the incoming request. Evaluated at the accepting edge, which
  // is the same value that gets latched, so it matches a check on the latch.
  logic misaligned_in;
  always_comb begin
    misaligned_in = 1'b0;
    case (size)
      2'b00:   misaligned_in = 1'b0;
      2'b01:   misaligned_in = addr[0];
      default: misaligned_in = |addr[1:0];  // word and reserved size
    endcase
  end

  // Load lane extraction from the live RAM read data.
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_val;
  always_comb begin
    load_byte = 8'h00;
    case (addr_q[1:0])
      2'd0: load_byte = ram_rdata[7:0];
      2'd1: load_byte = ram_rdata[15:8];
      2'd2: load_byte = ram_rdata[23:16];
      2'd3: load_byte = ram_rdata[31:24];
      default: load_byte = 8'h00;
    endcase
    load_half = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (size_q)
      2'b00:   load_val = {{24{sext_q & load_byte[7]}}, load_byte};
      2'b01:   load_val = {{16{sext_q & load_half[15]}}, load_half};
      default: load_val = ram_rdata;
    endcase
  end

  // Store data: merge the new lane(s) into the word read during RD. A word
  // store never passes through RD, so it takes wdata directly.
  logic [31:0] store_val;
  always_comb begin
    store_val = merge_q;
    case (size_q)
      2'b00: begin
        case (addr_q[1:0])
          2'd0: store_val[7:0]   = wdata_q[7:0];
          2'd1: store_val[15:8]  = wdata_q[7:0];
          2'd2: store_val[23:16] = wdata_q[7:0];
          2'd3: store_val[31:24] = wdata_q[7:0];
          default: store_val = merge_q;
        endcase
      end
      2'b01: begin
        if (addr_q[1]) store_val[31:16] = wdata_q[15:0];
        else           store_val[15:0]  = wdata_q[15:0];
      end
      default: store_val = wdata_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (misaligned_in)          state_next = DONE;
          else if (we && size[1])     state_next = WR;
          else                        state_next = RD;
        end
      end
      RD:      state_next = we_q ? WR : DONE;
      WR:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      merge_q <= 32'h0;
      rdata   <= 32'h0;
    end else begin
      if (state == IDLE && req) begin
        we_q    <= we;
        size_q  <= size;
        sext_q  <= sign_ext;
        addr_q  <= addr[AW+1:0];
        wdata_q <= wdata;
        err_q   <= misaligned_in;
      end
      if (state == RD) begin
        if (we_q) merge_q <= ram_rdata;
        else      rdata   <= load_val;
      end
    end
  end

  // Outputs are decoded from the state so an asynchronous reset drops the RAM
  // enables immediately, aborting any access that has not reached its WR edge.
  assign busy      = (state != IDLE);
  assign ack       = (state == DONE);
  assign addr_err  = (state == DONE) && err_q;
  assign ram_rEna  = (state == RD);
  assign ram_wEna  = (state == WR);
  assign ram_addr  = addr_q[AW+1:2];
  assign ram_wdata = (state == WR) ? store_val : 32'h0;

endmodule
